fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Parametrised butterfly-stage control sequencer for the pipelined FFT datapath. It replaces the per-stage fixed counters with one configurable block. It counts samples within a multi-phase frame, where each phase is NUM samples. It drives the add/sub enable, a delayed multiplier enable, the phase index (shift_type) and an end-of-frame pulse. One instance sits beside each butterfly stage, and its parameters select 2-phase (single butterfly) or 4-phase (dual shift-type) operation.

## Interface
Parameters:
- NUM, 16: samples per phase; ≥2, power of two.
- PHASES, 2: phases per frame; 2 or 4.
- GATED_PHASES, 1: leading phases that advance only on accepted valid; 1..PHASES. Later phases free-run.
- VALID_DLY, 0: 1 registers valid once before use; 0 uses valid directly.
- MUL_LAT, 1: cycles from bfly_add_sub_en to bfly_mul_en; 1..4.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- valid, input, 1: input sample valid.
- sync_clr, input, 1: synchronous frame abort/restart.
- bfly_add_sub_en, output, 1: butterfly add/sub enable.
- bfly_mul_en, output, 1: twiddle multiplier enable.
- shift_type, output, PH_W: current phase index.
- cnt_o, output, CNT_W: sample index within the current phase.
- frame_done, output, 1: one-cycle pulse after the last phase wraps.

## Operation
- Internal state:
  - cnt, CNT_W bits.
  - phase, PH_W bits, driven on shift_type.
  - valid_q, present only when VALID_DLY=1.
  - mul pipeline, MUL_LAT bits.
- v_eff = VALID_DLY ? valid_q : valid.
- cnt_en = (phase < GATED_PHASES) ? v_eff : 1.
- When cnt_en is high and cnt < NUM-1: cnt increments.
- When cnt_en is high and cnt == NUM-1:
  - cnt <= 0.
  - phase <= (phase == PHASES-1) ? 0 : phase+1.
  - bfly_add_sub_en <= LSB of next phase, so odd phases are butterfly phases.
  - frame_done <= 1 if phase wrapped to 0, else 0.
- frame_done is 0 on every other cycle.
- When cnt_en is low, all state holds.
- bfly_mul_en = bfly_add_sub_en delayed by exactly MUL_LAT cycles through a shift register, updated every cycle regardless of cnt_en.
- sync_clr takes priority over counting. It zeroes cnt, phase, valid_q, bfly_add_sub_en, frame_done and the whole mul pipeline on the next edge.
- valid asserted during a free-running phase is ignored. It is neither an error nor buffered.

## Timing
- Reset: every output and internal register is 0 immediately on rst high, asynchronously, and stays 0 while rst is high. The first count occurs on the first edge after rst falls with cnt_en high.
- bfly_add_sub_en, shift_type and frame_done are registered. They change on the edge that accepts sample NUM-1, so they are visible one cycle after that sample is presented (plus one more cycle when VALID_DLY=1).
- The add/sub window is exactly NUM consecutive cycles in free-running odd phases. In gated odd phases it lasts until NUM valids have been accepted.
- bfly_mul_en reproduces the bfly_add_sub_en waveform exactly, shifted by MUL_LAT cycles. The trailing mul window still completes after a frame wraps. It is truncated only by sync_clr or rst.
- Wrap-around: phase PHASES-1 → 0, with cnt NUM-1 → 0 on the same edge.
- Simultaneous sync_clr and a terminal count: sync_clr wins and frame_done stays 0.
- rst mid-frame: the partial frame is discarded with no frame_done.

## Structure
- Shared package fft_ctrl_pkg holds:
  - CNT_W = $clog2(NUM).
  - PH_W = max(1, $clog2(PHASES)).
  - Phase constants PH_FILL0=0, PH_BFLY0=1, PH_FILL1=2, PH_BFLY1=3.
- One sub-module, enable_delay_line (parameters DEPTH; ports clk, rst, clr, d, q). It implements the mul pipeline and is reusable for other stage enables.
- Elaboration-time assertions check every parameter range listed under Interface.

## Test plan
- NUM=4, PHASES=2, GATED=1, VALID_DLY=0, MUL_LAT=1; valid high cycles 0–3:
  - add_sub_en=1 and shift_type=1 in cycles 4–7.
  - mul_en=1 in cycles 5–8.
  - frame_done=1 in cycle 8 only.
- Same config; valid high cycles 0–1, low 2–4, high 5–6:
  - add_sub_en rises in cycle 7.
  - cnt_o holds at 2 during cycles 2–4.
- NUM=4, PHASES=4, GATED=2, VALID_DLY=1, MUL_LAT=1; valid high cycles 0–7:
  - shift_type=1 and add_sub_en=1 in cycles 5–8.
  - shift_type=2 and add_sub_en=0 in cycles 9–12.
  - shift_type=3 and add_sub_en=1 in cycles 13–16.
  - shift_type=0 and frame_done=1 in cycle 17.
- MUL_LAT=3, first config: mul_en=1 in cycles 7–10.
- sync_clr pulsed in cycle 5 of the first scenario:
  - cycle 6: cnt_o=0, shift_type=0, add_sub_en=0, mul_en=0.
  - no frame_done.
  - a fresh 4-valid burst then repeats the scenario-1 waveform.
- rst asserted mid-cycle during phase 1: all outputs drop to 0 before the next clk edge; normal operation resumes after release.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for FFT stage control: phase indices and width helpers.
// Widths depend on per-instance parameters, so they are derived through functions.
package fft_ctrl_pkg;

   localparam int PH_FILL0 = 0;
   localparam int PH_BFLY0 = 1;
   localparam int PH_FILL1 = 2;
   localparam int PH_BFLY1 = 3;

   function automatic int cnt_width(input int num);
      return (num < 2) ? 1 : $clog2(num);
   endfunction

   function automatic int ph_width(input int phases);
      return (phases <= 2) ? 1 : $clog2(phases);
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/enable_delay_line.sv
// Fixed-depth shift register for 1-bit stage enables; clr empties it synchronously.
// Latency DEPTH cycles, shifts every cycle (no stall input).
module enable_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sr;

   generate
      if (DEPTH == 1) begin : g_one
         always_ff @(posedge clk or posedge rst) begin
            if (rst)      sr <= '0;
            else if (clr) sr <= '0;
            else          sr <= d;
         end
      end else begin : g_multi
         always_ff @(posedge clk or posedge rst) begin
            if (rst)      sr <= '0;
            else if (clr) sr <= '0;
            else          sr <= {sr[DEPTH-2:0], d};
         end
      end
   endgenerate

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Butterfly-stage sequencer: counts NUM samples per phase over PHASES phases,
// gating the leading phases on valid; odd phases enable the add/sub butterfly.
module fft_stage_sequencer
   import fft_ctrl_pkg::*;
#(
   parameter  int NUM          = 16,
   parameter  int PHASES       = 2,
   parameter  int GATED_PHASES = 1,
   parameter  int VALID_DLY    = 0,
   parameter  int MUL_LAT      = 1,
   localparam int CNT_W        = cnt_width(NUM),
   localparam int PH_W         = ph_width(PHASES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid,
   input  logic             sync_clr,
   output logic             bfly_add_sub_en,
   output logic             bfly_mul_en,
   output logic [PH_W-1:0]  shift_type,
   output logic [CNT_W-1:0] cnt_o,
   output logic             frame_done
);

   generate
      if (NUM < 2 || !is_pow2(NUM))
         $error("NUM must be a power of two >= 2");
      if (PHASES != 2 && PHASES != 4)
         $error("PHASES must be 2 or 4");
      if (GATED_PHASES < 1 || GATED_PHASES > PHASES)
         $error("GATED_PHASES must be in 1..PHASES");
      if (VALID_DLY != 0 && VALID_DLY != 1)
         $error("VALID_DLY must be 0 or 1");
      if (MUL_LAT < 1 || MUL_LAT > 4)
         $error("MUL_LAT must be in 1..4");
   endgenerate

   logic [CNT_W-1:0] cnt;
   logic [PH_W-1:0]  phase;
   logic [PH_W-1:0]  next_ph;
   logic             valid_q;
   logic             v_eff;
   logic             cnt_en;
   logic             last_cnt;
   logic             last_ph;

   generate
      if (VALID_DLY == 1) begin : g_vdly
         always_ff @(posedge clk or posedge rst) begin
            if (rst)           valid_q <= 1'b0;
            else if (sync_clr) valid_q <= 1'b0;
            else               valid_q <= valid;
         end
         assign v_eff = valid_q;
      end else begin : g_vdir
         assign valid_q = 1'b0;
         assign v_eff   = valid;
      end
   endgenerate

   // Trailing phases free-run: valid there is deliberately ignored.
   assign cnt_en   = (32'(phase) < GATED_PHASES) ? v_eff : 1'b1;
   assign last_cnt = (cnt == CNT_W'(NUM - 1));
   assign last_ph  = (phase == PH_W'(PHASES - 1));
   assign next_ph  = last_ph ? '0 : phase + PH_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt             <= '0;
         phase           <= '0;
         bfly_add_sub_en <= 1'b0;
         frame_done      <= 1'b0;
      end else if (sync_clr) begin
         cnt             <= '0;
         phase           <= '0;
         bfly_add_sub_en <= 1'b0;
         frame_done      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (cnt_en) begin
            if (last_cnt) begin
               cnt             <= '0;
               phase           <= next_ph;
               bfly_add_sub_en <= next_ph[0];
               frame_done      <= last_ph;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   // Free-running so the multiplier window completes even after the frame wraps.
   enable_delay_line #(.DEPTH(MUL_LAT)) u_mul_dly (
      .clk (clk),
      .rst (rst),
      .clr (sync_clr),
      .d   (bfly_add_sub_en),
      .q   (bfly_mul_en)
   );

   assign shift_type = phase;
   assign cnt_o      = cnt;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: three sequencer configurations share clock and stimulus,
// each cycle's outputs are compared against hand-derived waveforms.
module tb_fft_stage_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic valid = 1'b0;
   logic sync_clr = 1'b0;

   int vectors = 0;
   int errors  = 0;

   logic       a_add, a_mul, a_fd;
   logic [0:0] a_sh;
   logic [1:0] a_cnt;
   logic       b_add, b_mul, b_fd;
   logic [1:0] b_sh;
   logic [1:0] b_cnt;
   logic       c_add, c_mul, c_fd;
   logic [0:0] c_sh;
   logic [1:0] c_cnt;

   always #5 clk = ~clk;

   fft_stage_sequencer #(.NUM(4), .PHASES(2), .GATED_PHASES(1), .VALID_DLY(0), .MUL_LAT(1)) u_a (
      .clk(clk), .rst(rst), .valid(valid), .sync_clr(sync_clr),
      .bfly_add_sub_en(a_add), .bfly_mul_en(a_mul), .shift_type(a_sh),
      .cnt_o(a_cnt), .frame_done(a_fd));

   fft_stage_sequencer #(.NUM(4), .PHASES(4), .GATED_PHASES(2), .VALID_DLY(1), .MUL_LAT(1)) u_b (
      .clk(clk), .rst(rst), .valid(valid), .sync_clr(sync_clr),
      .bfly_add_sub_en(b_add), .bfly_mul_en(b_mul), .shift_type(b_sh),
      .cnt_o(b_cnt), .frame_done(b_fd));

   fft_stage_sequencer #(.NUM(4), .PHASES(2), .GATED_PHASES(1), .VALID_DLY(0), .MUL_LAT(3)) u_c (
      .clk(clk), .rst(rst), .valid(valid), .sync_clr(sync_clr),
      .bfly_add_sub_en(c_add), .bfly_mul_en(c_mul), .shift_type(c_sh),
      .cnt_o(c_cnt), .frame_done(c_fd));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic bit in_r(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, " a_add"}, 32'(a_add), 0);
      chk({tag, " a_mul"}, 32'(a_mul), 0);
      chk({tag, " a_sh"},  32'(a_sh),  0);
      chk({tag, " a_cnt"}, 32'(a_cnt), 0);
      chk({tag, " a_fd"},  32'(a_fd),  0);
      chk({tag, " b_sh"},  32'(b_sh),  0);
      chk({tag, " c_mul"}, 32'(c_mul), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = 1'b0;
      sync_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_all_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Four valids: butterfly window cycles 4-7, mul 5-8 (7-10 at MUL_LAT=3), done in 8.
   task automatic run_basic(input string tag);
      int exp_cnt;
      for (int c = 0; c <= 12; c++) begin
         @(posedge clk);
         #1 valid = (c <= 3);
         @(negedge clk);
         exp_cnt = in_r(c, 0, 3) ? c : (in_r(c, 4, 7) ? c - 4 : 0);
         chk($sformatf("%s add c%0d", tag, c), 32'(a_add), 32'(in_r(c, 4, 7)));
         chk($sformatf("%s sh c%0d",  tag, c), 32'(a_sh),  32'(in_r(c, 4, 7)));
         chk($sformatf("%s mul c%0d", tag, c), 32'(a_mul), 32'(in_r(c, 5, 8)));
         chk($sformatf("%s fd c%0d",  tag, c), 32'(a_fd),  32'(c == 8));
         chk($sformatf("%s cnt c%0d", tag, c), 32'(a_cnt), 32'(exp_cnt));
         chk($sformatf("%s mul3 c%0d", tag, c), 32'(c_mul), 32'(in_r(c, 7, 10)));
      end
      valid = 1'b0;
   endtask

   initial begin
      // Scenario 1 plus MUL_LAT=3 variant
      do_reset();
      run_basic("s1");

      // Scenario 2: stalled gated phase
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         @(posedge clk);
         #1 valid = (c <= 1) || (c == 5) || (c == 6);
         @(negedge clk);
         if (in_r(c, 2, 4))
            chk($sformatf("s2 cnt c%0d", c), 32'(a_cnt), 2);
         chk($sformatf("s2 add c%0d", c), 32'(a_add), 32'(in_r(c, 7, 10)));
      end
      valid = 1'b0;

      // Scenario 3: 4-phase, two gated phases, registered valid
      do_reset();
      for (int c = 0; c <= 19; c++) begin
         int exp_sh;
         @(posedge clk);
         #1 valid = (c <= 7);
         @(negedge clk);
         exp_sh = in_r(c, 5, 8) ? 1 : in_r(c, 9, 12) ? 2 : in_r(c, 13, 16) ? 3 : 0;
         chk($sformatf("s3 sh c%0d",  c), 32'(b_sh),  32'(exp_sh));
         chk($sformatf("s3 add c%0d", c), 32'(b_add), 32'(in_r(c, 5, 8) || in_r(c, 13, 16)));
         chk($sformatf("s3 mul c%0d", c), 32'(b_mul), 32'(in_r(c, 6, 9) || in_r(c, 14, 17)));
         chk($sformatf("s3 fd c%0d",  c), 32'(b_fd),  32'(c == 17));
      end
      valid = 1'b0;

      // Scenario 4: sync_clr in cycle 5, then a fresh burst from cycle 10
      do_reset();
      for (int c = 0; c <= 20; c++) begin
         bit exp_add;
         @(posedge clk);
         #1;
         valid    = (c <= 3) || in_r(c, 10, 13);
         sync_clr = (c == 5);
         @(negedge clk);
         exp_add = in_r(c, 4, 5) || in_r(c, 14, 17);
         chk($sformatf("s4 add c%0d", c), 32'(a_add), 32'(exp_add));
         chk($sformatf("s4 sh c%0d",  c), 32'(a_sh),  32'(exp_add));
         chk($sformatf("s4 mul c%0d", c), 32'(a_mul), 32'((c == 5) || in_r(c, 15, 18)));
         chk($sformatf("s4 fd c%0d",  c), 32'(a_fd),  32'(c == 18));
         chk($sformatf("s4 mul3 c%0d", c), 32'(c_mul), 32'(in_r(c, 17, 20)));
         if (c == 6)
            chk("s4 cnt c6", 32'(a_cnt), 0);
      end
      valid = 1'b0;
      sync_clr = 1'b0;

      // Scenario 5: async reset mid-cycle during the butterfly phase
      do_reset();
      for (int c = 0; c <= 4; c++) begin
         @(posedge clk);
         #1 valid = (c <= 3);
      end
      @(posedge clk);
      #1 valid = 1'b0;
      chk("s5 pre add", 32'(a_add), 1);
      chk("s5 pre sh",  32'(a_sh),  1);
      #2 rst = 1'b1;
      #1 chk_all_zero("s5 async");
      @(posedge clk);
      #1 chk_all_zero("s5 held");
      rst = 1'b0;
      run_basic("s5 resume");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
